// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types: register-file write request and arbitration source tags.
package wb_arbiter_pkg;
  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [XLEN-1:0]   wd;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO,
    SRC_LU
  } wb_src_t;
endpackage

// File: rtl/wb_arbiter_fifo.sv
// Circular buffer for long-latency writeback requests; head visible combinationally, one-cycle
// push-to-pop latency; caller must not push when full or pop when empty.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push,
  input  wb_req_t         push_dat,
  input  logic            pop,
  output wb_req_t         head_dat,
  output logic            full,
  output logic            empty,
  output logic [CNTW-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0]   PTR_ONE = 1;
  localparam logic [CNTW-1:0] CNT_ONE = 1;

  wb_req_t         mem_q [DEPTH];
  wb_req_t         mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CNTW'(DEPTH));
  assign empty    = (count_q == '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Storage carries no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rstn) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rstn) !(pop && empty));
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU > FIFO head > direct long result onto a registered write port, 1 cycle;
// long-latency input backpressured only by a full FIFO; per-register pending scoreboard.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              alu_we,
  input  logic [REG_AW-1:0] alu_wa,
  input  logic [XLEN-1:0]   alu_wd,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_AW-1:0] lu_wa,
  input  logic [XLEN-1:0]   lu_wd,
  input  logic              iss_mark,
  input  logic [REG_AW-1:0] iss_wa,
  output logic              we3,
  output logic [REG_AW-1:0] wa3,
  output logic [XLEN-1:0]   wd3,
  output logic [31:0]       busy,
  output logic [CNTW-1:0]   q_count
);
  wb_src_t           src;
  wb_req_t           sel_req, lu_req, alu_req, fifo_head;
  logic              lu_hs, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic              we3_q, we3_d, lng_q, lng_d;
  logic [REG_AW-1:0] wa3_q, wa3_d;
  logic [XLEN-1:0]   wd3_q, wd3_d;
  logic [31:0]       busy_q, busy_d;

  assign lu_req   = '{wa: lu_wa, wd: lu_wd};
  assign alu_req  = '{wa: alu_wa, wd: alu_wd};
  assign lu_ready = !fifo_full;
  assign lu_hs    = lu_valid && lu_ready;

  wb_fifo #(.DEPTH(DEPTH), .CNTW(CNTW)) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (fifo_push),
    .push_dat (lu_req),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (q_count)
  );

  // An accepted long result only bypasses the FIFO when nothing older or higher-priority wants the port.
  always_comb begin
    src       = SRC_NONE;
    sel_req   = lu_req;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (alu_we) begin
      src       = SRC_ALU;
      sel_req   = alu_req;
      fifo_push = lu_hs;
    end else if (!fifo_empty) begin
      src       = SRC_FIFO;
      sel_req   = fifo_head;
      fifo_pop  = 1'b1;
      fifo_push = lu_hs;
    end else if (lu_hs) begin
      src = SRC_LU;
    end
  end

  always_comb begin
    we3_d = (src != SRC_NONE) && (sel_req.wa != '0);
    lng_d = we3_d && ((src == SRC_FIFO) || (src == SRC_LU));
    wa3_d = wa3_q;
    wd3_d = wd3_q;
    if (src != SRC_NONE) begin
      wa3_d = sel_req.wa;
      wd3_d = sel_req.wd;
    end
    // Clear one cycle after the long write is on the port, so readers see the new value first.
    busy_d = busy_q;
    if (lng_q) begin
      busy_d[wa3_q] = 1'b0;
    end
    if (iss_mark && (iss_wa != '0)) begin
      busy_d[iss_wa] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we3_q  <= 1'b0;
      wa3_q  <= '0;
      wd3_q  <= '0;
      lng_q  <= 1'b0;
      busy_q <= '0;
    end else begin
      we3_q  <= we3_d;
      wa3_q  <= wa3_d;
      wd3_q  <= wd3_d;
      lng_q  <= lng_d;
      busy_q <= busy_d;
    end
  end

  assign we3  = we3_q;
  assign wa3  = wa3_q;
  assign wd3  = wd3_q;
  assign busy = busy_q;

  a_mark_not_busy: assert property (@(posedge clk) disable iff (!rstn)
    !(iss_mark && (iss_wa != '0) && busy_q[iss_wa] && !(lng_q && (wa3_q == iss_wa))));
  a_alu_not_busy: assert property (@(posedge clk) disable iff (!rstn)
    !(alu_we && busy_q[alu_wa]));
  a_lu_dest_busy: assert property (@(posedge clk) disable iff (!rstn)
    !(lu_valid && !busy_q[lu_wa]));
  a_lu_stable: assert property (@(posedge clk) disable iff (!rstn)
    (lu_valid && !lu_ready) |=> ((lu_wa == $past(lu_wa)) && (lu_wd == $past(lu_wd))));
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file; drives its single write port (we3/wa3/wd3).
- Merges two result sources:
  - single-cycle ALU results, which are never stalled;
  - long-latency results (load/FPU), accepted through a valid/ready handshake.
- Long-latency results that lose arbitration are held in a small FIFO.
- Keeps a per-register pending scoreboard so issue logic can stall on RAW/WAW hazards against outstanding long-latency ops.

Parameters:
- DEPTH, 4, long-latency result FIFO entries (power of two, >=2)
- CNTW, $clog2(DEPTH)+1, width of the occupancy count

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- alu_we  in  1  ALU result valid this cycle
- alu_wa  in  5  ALU destination register
- alu_wd  in  32  ALU result
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  long-latency result accepted (handshake completes when valid&ready)
- lu_wa  in  5  long-latency destination register
- lu_wd  in  32  long-latency result
- iss_mark  in  1  issue stage dispatching a long-latency op this cycle
- iss_wa  in  5  destination of that op
- we3  out  1  register file write enable (registered)
- wa3  out  5  register file write address (registered)
- wd3  out  32  register file write data (registered)
- busy  out  32  scoreboard; bit r set means register r has an outstanding long-latency write
- q_count  out  CNTW  current FIFO occupancy

Behaviour:
- Reset (rstn=0, asynchronous): we3=0, wa3=0, wd3=0, busy=0, FIFO empty, q_count=0. After release, lu_ready=1.
- lu_ready = (q_count != DEPTH), combinational from state only. It does not depend on lu_valid or alu_we. A same-cycle dequeue does not free a slot early.
- Output register update each posedge, selecting a write source in priority order:
  1. ALU: if alu_we, write {alu_wa, alu_wd}. A long-latency handshake in the same cycle enqueues.
  2. FIFO head: else if FIFO non-empty, write the head and pop it. A same-cycle handshake enqueues, so push and pop together keep q_count unchanged.
  3. Direct: else if lu_valid&lu_ready, write {lu_wa, lu_wd} straight to the output, with no FIFO entry.
  4. Idle: else we3=0. wa3/wd3 hold their previous values.
- Latency:
  - ALU and direct long results appear on we3 exactly one cycle after the input.
  - Buffered results leave in FIFO order (oldest first), at the first ALU-idle cycle.
- x0 rule: any selected write with destination 0 produces we3=0 for that cycle; a FIFO pop still occurs. Scoreboard bit 0 is never set.
- Scoreboard:
  - Set: iss_mark with iss_wa!=0 sets busy[iss_wa] at the next edge.
  - Clear: busy[wa3] clears on the edge that completes a long-latency write, i.e. the cycle after we3 asserts from a long source. It is not cleared at enqueue, so busy falls no earlier than the value is readable from the register file.
  - Set and clear of the same register on the same edge: set wins.
  - ALU writes never clear busy.
- Protocol obligations on neighbours (assertion-checked in simulation):
  - the issue stage never marks a register that is already busy;
  - the issue stage never issues an ALU op whose destination is busy, so ALU/long WAW to one register cannot occur;
  - every long-latency result's lu_wa is busy when presented;
  - lu_wa/lu_wd are stable while lu_valid&!lu_ready.
- FIFO:
  - circular buffer with read/write pointers wrapping at DEPTH;
  - full and empty derived from q_count;
  - pushing when full and popping when empty are impossible by construction (asserted).
- Reset mid-operation: buffered results and busy bits are discarded. Upstream units are flushed by the same reset.

Decomposition:
- Shared package (core pkg):
  - REG_AW=5, XLEN=32;
  - wb_req_t struct {logic [4:0] wa; logic [31:0] wd;};
  - enum wb_src_t {SRC_NONE, SRC_ALU, SRC_FIFO, SRC_LU}, used for the output mux and debug.
- Natural sub-module: wb_fifo, a parameterized DEPTH x wb_req_t synchronous FIFO with push/pop/full/empty/count and an rstn async clear.
- Arbitration, scoreboard and output register stay in wb_arbiter.

Test Plan:
- Reset then idle -> we3=0, busy=0, q_count=0, lu_ready=1. Assert rstn low mid-run with 2 entries queued -> q_count=0, busy=0 immediately.
- alu_we=1, alu_wa=5, alu_wd=0xDEADBEEF -> next cycle we3=1, wa3=5, wd3=0xDEADBEEF. Same with alu_wa=0 -> we3=0.
- iss_mark wa=7; later lu_valid wa=7, wd=0x12345678 with ALU idle and FIFO empty:
  - next cycle we3=1, wa3=7;
  - busy[7]=1 through that cycle, 0 the cycle after.
- ALU busy on 6 consecutive cycles while lu_valid presents wa=1..6 (all marked):
  - lu_ready drops after 4 accepts, q_count=4;
  - after ALU idles, writes 1,2,3,4 then 5,6 leave in order, one per cycle.
- Full FIFO, ALU idle, lu_valid held -> each cycle pops the head while lu_ready=0. Next cycle lu_ready=1, and push+pop keeps q_count=3.
- Same cycle: iss_mark wa=9 and a long write of wa3=9 completing -> busy[9]=1 afterwards.
